xbar_rr_sched: RTL
==================

Name: xbar_rr_sched

Overview:
- Packet-aware round-robin scheduler for the 4-input x 8-output crossbar.
- Each input FIFO presents its head-of-line (HOL) beat: valid, destination port, end-of-packet flag.
- Block issues combinational per-input pop grants, plus registered per-output mux selects aligned with the crossbar's registered output stage.
- Once an output starts a multi-beat packet from one input, it stays locked to that input until EOP; this prevents beat interleaving.

Parameters:
- NUM_IN, 4, number of input queues (requesters).
- NUM_OUT, 8, number of output ports.
- IN_W, log2(NUM_IN)=2, width of a source index.
- OUT_W, log2(NUM_OUT)=3, width of a destination index.
- LOCK_TIMEOUT, 256, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_IN  HOL beat present (FIFO not empty), one bit per input
- req_dst  in  NUM_IN*OUT_W  HOL destination; input i in bits [i*OUT_W +: OUT_W]
- req_eop  in  NUM_IN  HOL beat is last of packet
- out_ready  in  NUM_OUT  output port can accept a beat this cycle
- grant  out  NUM_IN  combinational pop/read-enable per input
- sel_valid  out  NUM_OUT  registered: output o carries a beat this cycle
- sel_src  out  NUM_OUT*IN_W  registered: source input for output o
- err_bad_dst  out  1  sticky: a request named a port >= NUM_OUT
- err_timeout  out  1  sticky: lock watchdog fired (0 without the optional feature)

Behaviour:
- Reset (rst=1 at clk edge):
  - all rr_ptr[o] = 0; all outputs IDLE; owner = 0
  - sel_valid = 0, sel_src = 0, err_bad_dst = 0, err_timeout = 0
  - grant is forced 0 while rst=1.
  - Reset mid-packet drops the lock immediately; the next packet arbitrates fresh.
- Candidates: input i is a candidate for output o when req_valid[i] && req_dst[i]==o. Each input targets one output, so each input gets at most one grant.
- Per-output FSM, state IDLE:
  - If out_ready[o] and candidates exist, grant the first candidate at or after rr_ptr[o], searching cyclically modulo NUM_IN.
  - Granted beat with req_eop=1: stay IDLE; rr_ptr[o] <= winner+1 mod NUM_IN.
  - Granted beat with req_eop=0: go LOCKED; owner[o] <= winner; rr_ptr unchanged.
- Per-output FSM, state LOCKED:
  - Only owner[o] is eligible. Grant it when it is a candidate and out_ready[o]=1.
  - Granted beat with req_eop=1: go IDLE; rr_ptr[o] <= owner+1.
  - Owner not requesting, or out_ready[o]=0: stay LOCKED, no grant. Other inputs targeting o wait.
- out_ready[o]=0: no grant to o in either state; FSM state and pointer hold.
- Bad destination (req_valid[i] && req_dst[i] >= NUM_OUT, only possible if NUM_OUT is not a power of 2):
  - grant[i]=1 that cycle, so the beat is discarded.
  - No sel_valid asserted.
  - err_bad_dst <= 1, sticky until reset.
- Latency:
  - grant is combinational, same cycle as the request.
  - sel_valid[o]/sel_src[o] register the grant decision one cycle later, matching the registered crossbar data.
  - A grant to output o in cycle t gives sel_valid[o]=1 in cycle t+1; otherwise sel_valid[o]=0.
- Throughput: one beat per output per cycle; all 8 outputs can be active simultaneously.

Optional Feature:
- Macro: XBAR_SCHED_LOCK_TIMEOUT_EN.
- When defined:
  - Per-output counter increments each cycle the output is LOCKED without granting its owner; it clears on any owner grant and on leaving LOCKED.
  - When the counter reaches LOCK_TIMEOUT-1: force IDLE, rr_ptr[o] <= owner+1, err_timeout <= 1 (sticky).
- When undefined: no counters; err_timeout tied 0; a lock waits forever.

Decomposition:
- Package xbar_sched_pkg holds:
  - NUM_IN/NUM_OUT defaults
  - IN_W/OUT_W and a log2 constant function
  - output FSM state encoding (IDLE=0, LOCKED=1)
- One sub-module: xbar_out_arb, instantiated NUM_OUT times via generate. It holds the FSM, rr_ptr, owner and optional watchdog for one output, and produces a one-hot per-input grant vector.
- Top level: ORs each input's grant bits across all outputs (plus bad-dst grants) to form grant, and registers sel_valid/sel_src.

Test Plan:
1. Reset, then inputs 0..3 all send single-beat (eop=1) packets to port 5, all out_ready=1 → grants in order 0,1,2,3 on successive cycles; sel_src[5] shows 0,1,2,3 one cycle later; rr_ptr[5] ends at 0.
2. Input 2 sends a 3-beat packet to port 1 while input 0 requests port 1 from cycle 1 → beats from input 2 granted cycles 0–2, input 0 granted cycle 3; no interleave.
3. Input 1 locked on port 7, out_ready[7]=0 for 4 cycles → no grant to port 7, sel_valid[7]=0; then ready=1 and remaining beats flow.
4. Inputs 0→2, 1→3, 2→4, 3→6 at once → all four grant=1 in the same cycle; sel_valid = 8'b0101_1100 next cycle.
5. Assert rst while port 4 is LOCKED mid-packet → next cycle all sel_valid=0; a new request from another input to port 4 is granted immediately.
6. With XBAR_SCHED_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=8: owner on port 0 stops requesting after a non-eop beat → port 0 returns to IDLE after 8 cycles and err_timeout=1; input 3 waiting on port 0 is granted the following cycle.

Source files
------------

// File: rtl/xbar_rr_sched_pkg.sv
// Shared constants, width helper and per-output arbiter state encoding for
// the crossbar round-robin scheduler.
package xbar_sched_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int p = 1; p < value; p = p * 2) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int DEFAULT_NUM_IN       = 4;
    localparam int DEFAULT_NUM_OUT      = 8;
    localparam int DEFAULT_IN_W         = clog2(DEFAULT_NUM_IN);
    localparam int DEFAULT_OUT_W        = clog2(DEFAULT_NUM_OUT);
    localparam int DEFAULT_LOCK_TIMEOUT = 256;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/xbar_rr_sched_if.sv
// Request/grant/select bundle between the input FIFOs, the scheduler and the
// crossbar output stage. The master side drives the requests.
interface xbar_rr_sched_if
    import xbar_sched_pkg::*;
#(
    parameter int NUM_IN  = DEFAULT_NUM_IN,
    parameter int NUM_OUT = DEFAULT_NUM_OUT,
    parameter int IN_W    = clog2(NUM_IN),
    parameter int OUT_W   = clog2(NUM_OUT)
);
    logic [NUM_IN-1:0]         req_valid;
    logic [NUM_IN*OUT_W-1:0]   req_dst;
    logic [NUM_IN-1:0]         req_eop;
    logic [NUM_OUT-1:0]        out_ready;
    logic [NUM_IN-1:0]         grant;
    logic [NUM_OUT-1:0]        sel_valid;
    logic [NUM_OUT*IN_W-1:0]   sel_src;
    logic                      err_bad_dst;
    logic                      err_timeout;

    modport master (
        output req_valid, req_dst, req_eop, out_ready,
        input  grant, sel_valid, sel_src, err_bad_dst, err_timeout
    );

    modport slave (
        input  req_valid, req_dst, req_eop, out_ready,
        output grant, sel_valid, sel_src, err_bad_dst, err_timeout
    );
endinterface

// File: rtl/xbar_rr_sched_out_arb.sv
// One output's packet-locking round-robin arbiter (module xbar_out_arb).
// Optional lock watchdog enabled by XBAR_SCHED_LOCK_TIMEOUT_EN.
module xbar_out_arb
    import xbar_sched_pkg::*;
#(
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int IN_W   = clog2(NUM_IN)
`ifdef XBAR_SCHED_LOCK_TIMEOUT_EN
    , parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] cand,
    input  logic [NUM_IN-1:0] eop,
    input  logic              ready,
    output logic [NUM_IN-1:0] gnt,
    output logic [IN_W-1:0]   src,
    output logic              timeout
);
    arb_state_e      state_q, state_d;
    logic [IN_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IN_W-1:0] owner_q, owner_d;
    logic [IN_W-1:0] win;
    logic            found;

    function automatic logic [IN_W-1:0] wrap_add(input logic [IN_W-1:0] base, input int k);
        return IN_W'((int'(base) + k) % NUM_IN);
    endfunction

    // First candidate at or after the pointer, cyclically.
    always_comb begin
        found = 1'b0;
        win   = rr_ptr_q;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!found && cand[wrap_add(rr_ptr_q, k)]) begin
                found = 1'b1;
                win   = wrap_add(rr_ptr_q, k);
            end
        end
    end

`ifdef XBAR_SCHED_LOCK_TIMEOUT_EN
    localparam int WD_W = clog2(LOCK_TIMEOUT);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_fire;

    assign wd_fire = (wd_q == WD_W'(LOCK_TIMEOUT - 1));
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        gnt      = '0;
        src      = owner_q;
        timeout  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                src = win;
                if (ready && found) begin
                    gnt[win] = 1'b1;
                    if (eop[win]) begin
                        rr_ptr_d = wrap_add(win, 1);
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = win;
                    end
                end
            end
            ST_LOCKED: begin
                if (ready && cand[owner_q]) begin
                    gnt[owner_q] = 1'b1;
                    if (eop[owner_q]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = wrap_add(owner_q, 1);
                    end
                end
`ifdef XBAR_SCHED_LOCK_TIMEOUT_EN
                else if (wd_fire) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = wrap_add(owner_q, 1);
                    timeout  = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef XBAR_SCHED_LOCK_TIMEOUT_EN
    // Counts stalled cycles of a lock that stays locked; any owner grant or exit clears it.
    always_comb begin
        wd_d = '0;
        if (state_q == ST_LOCKED && state_d == ST_LOCKED && !(|gnt)) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

endmodule

// File: rtl/xbar_rr_sched.sv
// Packet-aware round-robin scheduler for the 4x8 crossbar: combinational pops,
// registered output selects. Lock watchdog enabled by XBAR_SCHED_LOCK_TIMEOUT_EN.
module xbar_rr_sched
    import xbar_sched_pkg::*;
#(
    parameter int NUM_IN  = DEFAULT_NUM_IN,
    parameter int NUM_OUT = DEFAULT_NUM_OUT
`ifdef XBAR_SCHED_LOCK_TIMEOUT_EN
    , parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT
`endif
) (
    input  logic           clk,
    input  logic           rst,
    xbar_rr_sched_if.slave bus
);
    localparam int IN_W  = clog2(NUM_IN);
    localparam int OUT_W = clog2(NUM_OUT);

    logic [NUM_OUT-1:0][NUM_IN-1:0] cand;
    logic [NUM_OUT-1:0][NUM_IN-1:0] arb_gnt;
    logic [NUM_OUT-1:0][IN_W-1:0]   arb_src;
    logic [NUM_OUT-1:0]             arb_timeout;
    logic [NUM_IN-1:0]              bad_dst;
    logic [NUM_IN-1:0]              grant_c;

    logic [NUM_OUT-1:0]             sel_valid_q, sel_valid_d;
    logic [NUM_OUT-1:0][IN_W-1:0]   sel_src_q, sel_src_d;
    logic                           err_bad_dst_q, err_bad_dst_d;
    logic                           err_timeout_q, err_timeout_d;

    always_comb begin
        cand = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                cand[o][i] = bus.req_valid[i] &&
                             (bus.req_dst[i*OUT_W +: OUT_W] == OUT_W'(o));
            end
        end
    end

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        xbar_out_arb #(
            .NUM_IN       (NUM_IN),
            .IN_W         (IN_W)
`ifdef XBAR_SCHED_LOCK_TIMEOUT_EN
            , .LOCK_TIMEOUT (LOCK_TIMEOUT)
`endif
        ) u_arb (
            .clk     (clk),
            .rst     (rst),
            .cand    (cand[o]),
            .eop     (bus.req_eop),
            .ready   (bus.out_ready[o]),
            .gnt     (arb_gnt[o]),
            .src     (arb_src[o]),
            .timeout (arb_timeout[o])
        );
    end

    // Beats addressed past the last port are popped so they drain rather than block.
    always_comb begin
        bad_dst = '0;
        grant_c = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            bad_dst[i] = bus.req_valid[i] &&
                         ({1'b0, bus.req_dst[i*OUT_W +: OUT_W]} >= (OUT_W+1)'(NUM_OUT));
        end
        for (int o = 0; o < NUM_OUT; o++) begin
            grant_c = grant_c | arb_gnt[o];
        end
        grant_c = grant_c | bad_dst;
    end

    assign bus.grant = rst ? '0 : grant_c;

    always_comb begin
        sel_valid_d = '0;
        sel_src_d   = sel_src_q;
        for (int o = 0; o < NUM_OUT; o++) begin
            if (|arb_gnt[o]) begin
                sel_valid_d[o] = 1'b1;
                sel_src_d[o]   = arb_src[o];
            end
        end
        err_bad_dst_d = err_bad_dst_q | (|bad_dst);
        err_timeout_d = err_timeout_q | (|arb_timeout);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_valid_q   <= '0;
            sel_src_q     <= '0;
            err_bad_dst_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            sel_valid_q   <= sel_valid_d;
            sel_src_q     <= sel_src_d;
            err_bad_dst_q <= err_bad_dst_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.sel_valid   = sel_valid_q;
    assign bus.sel_src     = sel_src_q;
    assign bus.err_bad_dst = err_bad_dst_q;
    assign bus.err_timeout = err_timeout_q;

endmodule
